mont_exp_ctrl: RTL and testbench
================================

Name: mont_exp_ctrl

Overview:
- Sequencer that computes result = X^E mod M using one shared 512-bit Montgomery multiplier (montgomery: start/in_a/in_b/in_m/result/done).
- Sits between the RSA top level and the montgomery instance. Owns every multiplier operand mux and every start pulse.
- Handles conversion into the Montgomery domain (via R^2), the exponent bit loop, and conversion out (multiply by 1).

Parameters:
- WIDTH, 512: operand/modulus width; must equal the montgomery datapath width.
- E_WIDTH, 512: exponent register width.
- LEN_W, 10: width of the exponent-length input; must satisfy 2^LEN_W > E_WIDTH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- in_x  in  WIDTH  base, plain domain, < in_m.
- in_e  in  E_WIDTH  exponent.
- in_e_len  in  LEN_W  number of exponent bits to process, from bit in_e_len-1 down to bit 0; 0..E_WIDTH.
- in_m  in  WIDTH  odd modulus.
- in_r  in  WIDTH  R mod M, with R = 2^WIDTH.
- in_r2  in  WIDTH  R^2 mod M.
- result  out  WIDTH  X^E mod M; held until the next accepted start.
- done  out  1  one-cycle pulse when result is valid.
- busy  out  1  high from the cycle after start is accepted until the cycle done pulses, inclusive.
- mont_start  out  1  one-cycle start pulse to the multiplier.
- mont_a  out  WIDTH  multiplier operand A; stable from mont_start until mont_done.
- mont_b  out  WIDTH  multiplier operand B; same stability rule as mont_a.
- mont_m  out  WIDTH  modulus to the multiplier; the latched in_m.
- mont_result  in  WIDTH  multiplier output.
- mont_done  in  1  multiplier completion.

Behaviour:
- Reset values: result=0, done=0, busy=0, mont_start=0, mont_a=0, mont_b=0; state=IDLE.
- Reset mid-operation aborts the run and returns to IDLE; no done is issued.
- On start in IDLE: latch x, e, e_len, m, r, r2 into internal registers.
  - Inputs may change afterwards without effect.
  - start while busy=1 is ignored.
- Every multiplication uses the same handshake:
  - ISSUE state: drive operands and pulse mont_start for exactly one cycle.
  - WAIT state: sample mont_done starting the cycle after mont_start. mont_done seen in the mont_start cycle is ignored, because a stale level-high done may persist.
  - On the first qualifying mont_done=1, capture mont_result into the destination register.
- States:
  - IDLE
  - TO_MONT: xt = Mont(x, r2).
  - INIT: acc = r; idx = e_len. If e_len=0, go to FROM_MONT.
  - SQ: acc = Mont(acc, acc); idx = idx-1.
  - MUL: only if e[idx]=1, acc = Mont(acc, xt). Then return to SQ if idx>0, otherwise go to FROM_MONT.
  - FROM_MONT: result = Mont(acc, 1), where operand B is the constant 1 zero-extended to WIDTH.
  - DONE: done=1 for one cycle, busy drops in the following cycle, return to IDLE.
- Multiplication count, square-and-multiply mode: 2 + e_len + popcount(e[e_len-1:0]).
- Boundary cases:
  - e_len=0 gives result 1 mod M.
  - e=0 with e_len>0 gives 1 mod M.
  - in_e_len > E_WIDTH is clamped to E_WIDTH.
  - A final subtraction is not this block's job. The multiplier must return values < M.
- Start-to-done latency: sum of the multiplier latencies + 2 cycles per multiplication (ISSUE plus capture) + 3 cycles (INIT, DONE, accept).

Optional Feature:
- MONT_EXP_LADDER_EN defined: constant-time Montgomery ladder.
  - Initialise r0 = r, r1 = xt.
  - Per bit b = e[idx]: r(1-b) = Mont(r0, r1), then r(b) = Mont(r(b), r(b)).
  - Final: result = Mont(r0, 1).
  - Multiplication count is exactly 2 + 2·e_len, independent of the exponent value.
- Undefined: square-and-multiply as described in Behaviour; the r1 register and ladder muxes are not synthesised.

Decomposition:
- Package mont_exp_pkg contains:
  - state enum: IDLE, TO_MONT, INIT, SQ, MUL, FROM_MONT, DONE, plus the ISSUE/WAIT sub-phase encoding;
  - WIDTH/E_WIDTH defaults;
  - constant MONT_ONE.
- One natural sub-module: mont_exp_issue. It owns the ISSUE/WAIT handshake, the operand hold registers and the stale-done masking, and returns a one-cycle "captured" strobe with the result data.

Test Plan (bench uses a behavioural montgomery model with configurable latency L):
- WIDTH=8, M=13, R mod M=9, R^2 mod M=3, x=2, e=5, e_len=3, L=4 -> result=6, exactly 7 mont_start pulses (ladder build: 8), done pulses once.
- Same operands, e_len=0 -> result=1, 2 mont_start pulses, busy then done.
- 512-bit run: a = 0xb4d6...363b, e = 0x10001, e_len=17, M = 0xfe93...c393 -> result equals the Python pow(a,e,M); mont_a/mont_b are stable throughout every WAIT.
- Model holds mont_done high permanently between operations -> no multiplication is skipped; pulse count unchanged.
- start asserted while busy, with different inputs -> ignored; result matches the first request. Reset asserted mid-SQ -> all outputs zero next cycle, no done; a fresh start then completes correctly.
- Ladder build, e=0xFF vs e=0x80 with e_len=8 -> identical start-to-done cycle count.

Source files
------------

// File: rtl/mont_exp_pkg.sv
// Shared types and defaults for the Montgomery exponentiation sequencer.
package mont_exp_pkg;

    localparam int unsigned WIDTH_DEF   = 512;
    localparam int unsigned E_WIDTH_DEF = 512;
    localparam int unsigned LEN_W_DEF   = 10;

    // Operand B for the final conversion out of the Montgomery domain.
    localparam logic [WIDTH_DEF-1:0] MONT_ONE = WIDTH_DEF'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TO_MONT,
        S_INIT,
        S_SQ,
        S_MUL,
        S_FROM_MONT,
        S_DONE
    } state_e;

    typedef enum logic {
        PH_ISSUE,
        PH_WAIT
    } phase_e;

endpackage

// File: rtl/mont_exp_issue.sv
// Multiplier handshake: holds operands, pulses start, masks stale done, strobes the capture.
module mont_exp_issue #(
    parameter int unsigned WIDTH = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_c,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] mont_result,
    input  logic             mont_done,
    output logic             mont_start,
    output logic [WIDTH-1:0] mont_a,
    output logic [WIDTH-1:0] mont_b,
    output logic             cap_valid_c,
    output logic [WIDTH-1:0] cap_data_c
);

    logic             start_q, start_d;
    logic             wait_q, wait_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    // A done level seen in the start cycle may be left over from the previous operation.
    always_comb begin
        cap_valid_c = wait_q && !start_q && mont_done;
        cap_data_c  = mont_result;
        start_d     = issue_c;
        wait_d      = wait_q;
        a_d         = a_q;
        b_d         = b_q;
        if (issue_c) begin
            wait_d = 1'b1;
            a_d    = op_a;
            b_d    = op_b;
        end else if (cap_valid_c) begin
            wait_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_q <= 1'b0;
            wait_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            start_q <= start_d;
            wait_q  <= wait_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign mont_start = start_q;
    assign mont_a     = a_q;
    assign mont_b     = b_q;

endmodule

// File: rtl/mont_exp_ctrl.sv
// Montgomery exponentiation sequencer computing X^E mod M on one shared multiplier.
// Define MONT_EXP_LADDER_EN for the constant-time Montgomery ladder; default is square-and-multiply.
module mont_exp_ctrl
    import mont_exp_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned E_WIDTH = E_WIDTH_DEF,
    parameter int unsigned LEN_W   = LEN_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [E_WIDTH-1:0] in_e,
    input  logic [LEN_W-1:0]   in_e_len,
    input  logic [WIDTH-1:0]   in_m,
    input  logic [WIDTH-1:0]   in_r,
    input  logic [WIDTH-1:0]   in_r2,
    output logic [WIDTH-1:0]   result,
    output logic               done,
    output logic               busy,
    output logic               mont_start,
    output logic [WIDTH-1:0]   mont_a,
    output logic [WIDTH-1:0]   mont_b,
    output logic [WIDTH-1:0]   mont_m,
    input  logic [WIDTH-1:0]   mont_result,
    input  logic               mont_done
);

    state_e             state_q, state_d;
    phase_e             phase_q, phase_d;
    logic [WIDTH-1:0]   x_q, x_d, m_q, m_d, r_q, r_d, r2_q, r2_d;
    logic [WIDTH-1:0]   xt_q, xt_d, acc_q, acc_d, result_q, result_d;
    logic [E_WIDTH-1:0] e_q, e_d;
    logic [LEN_W-1:0]   e_len_q, e_len_d, idx_q, idx_d, idx_m1_c;
    logic               done_q, done_d, busy_q, busy_d;
    logic               mult_c, issue_c, bit_c, cap_valid_c;
    logic [WIDTH-1:0]   op_a_c, op_b_c, cap_data_c;
`ifdef MONT_EXP_LADDER_EN
    logic [WIDTH-1:0]   r1_q, r1_d;
`endif

    mont_exp_issue #(.WIDTH(WIDTH)) u_issue (
        .clk         (clk),
        .reset       (reset),
        .issue_c     (issue_c),
        .op_a        (op_a_c),
        .op_b        (op_b_c),
        .mont_result (mont_result),
        .mont_done   (mont_done),
        .mont_start  (mont_start),
        .mont_a      (mont_a),
        .mont_b      (mont_b),
        .cap_valid_c (cap_valid_c),
        .cap_data_c  (cap_data_c)
    );

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        x_d      = x_q;
        e_d      = e_q;
        e_len_d  = e_len_q;
        m_d      = m_q;
        r_d      = r_q;
        r2_d     = r2_q;
        xt_d     = xt_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        issue_c  = 1'b0;
        mult_c   = 1'b0;
        op_a_c   = acc_q;
        op_b_c   = acc_q;
`ifdef MONT_EXP_LADDER_EN
        r1_d     = r1_q;
`endif
        idx_m1_c = idx_q - LEN_W'(1);
        bit_c    = |(e_q & (E_WIDTH'(1) << idx_m1_c));

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = in_x;
                    e_d     = in_e;
                    e_len_d = (in_e_len > LEN_W'(E_WIDTH)) ? LEN_W'(E_WIDTH) : in_e_len;
                    m_d     = in_m;
                    r_d     = in_r;
                    r2_d    = in_r2;
                    busy_d  = 1'b1;
                    phase_d = PH_ISSUE;
                    state_d = S_TO_MONT;
                end
            end
            S_TO_MONT: begin
                mult_c = 1'b1;
                op_a_c = x_q;
                op_b_c = r2_q;
                if (cap_valid_c) begin
                    xt_d    = cap_data_c;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                acc_d   = r_q;
                idx_d   = e_len_q;
`ifdef MONT_EXP_LADDER_EN
                r1_d    = xt_q;
`endif
                state_d = (e_len_q == '0) ? S_FROM_MONT : S_SQ;
            end
`ifdef MONT_EXP_LADDER_EN
            // Ladder step 1: r(1-b) = r0 * r1 for the bit under idx-1.
            S_SQ: begin
                mult_c = 1'b1;
                op_a_c = acc_q;
                op_b_c = r1_q;
                if (cap_valid_c) begin
                    if (bit_c) acc_d = cap_data_c;
                    else       r1_d  = cap_data_c;
                    state_d = S_MUL;
                end
            end
            // Ladder step 2: r(b) = r(b)^2, then consume the bit.
            S_MUL: begin
                mult_c = 1'b1;
                op_a_c = bit_c ? r1_q : acc_q;
                op_b_c = bit_c ? r1_q : acc_q;
                if (cap_valid_c) begin
                    if (bit_c) r1_d  = cap_data_c;
                    else       acc_d = cap_data_c;
                    idx_d   = idx_m1_c;
                    state_d = (idx_m1_c != '0) ? S_SQ : S_FROM_MONT;
                end
            end
`else
            // Square, consume a bit, and skip MUL entirely when that bit is clear.
            S_SQ: begin
                mult_c = 1'b1;
                if (cap_valid_c) begin
                    acc_d = cap_data_c;
                    idx_d = idx_m1_c;
                    if (bit_c)                 state_d = S_MUL;
                    else if (idx_m1_c != '0)   state_d = S_SQ;
                    else                       state_d = S_FROM_MONT;
                end
            end
            S_MUL: begin
                mult_c = 1'b1;
                op_b_c = xt_q;
                if (cap_valid_c) begin
                    acc_d   = cap_data_c;
                    state_d = (idx_q != '0) ? S_SQ : S_FROM_MONT;
                end
            end
`endif
            S_FROM_MONT: begin
                mult_c = 1'b1;
                op_b_c = WIDTH'(MONT_ONE);
                if (cap_valid_c) begin
                    result_d = cap_data_c;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (mult_c && (phase_q == PH_ISSUE)) begin
            issue_c = 1'b1;
            phase_d = PH_WAIT;
        end else if (cap_valid_c) begin
            phase_d = PH_ISSUE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            phase_q  <= PH_ISSUE;
            x_q      <= '0;
            e_q      <= '0;
            e_len_q  <= '0;
            m_q      <= '0;
            r_q      <= '0;
            r2_q     <= '0;
            xt_q     <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef MONT_EXP_LADDER_EN
            r1_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            x_q      <= x_d;
            e_q      <= e_d;
            e_len_q  <= e_len_d;
            m_q      <= m_d;
            r_q      <= r_d;
            r2_q     <= r2_d;
            xt_q     <= xt_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
`ifdef MONT_EXP_LADDER_EN
            r1_q     <= r1_d;
`endif
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign mont_m = m_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Scoreboard bench for mont_exp_ctrl with a behavioural Montgomery multiplier of latency lat.
module tb_mont_exp_ctrl;

    localparam int unsigned W  = 512;
    localparam int unsigned EW = 512;
    localparam int unsigned LW = 10;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] m;
        int           nstart;
        int           cycles;
        int unsigned  start_cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  in_x, in_m, in_r, in_r2;
    logic [EW-1:0] in_e;
    logic [LW-1:0] in_e_len;
    logic [W-1:0]  result;
    logic          done, busy, mont_start;
    logic [W-1:0]  mont_a, mont_b, mont_m;
    logic [W-1:0]  mont_result = '0;
    logic          mont_done = 1'b0;

    int            tests = 0;
    int            fails = 0;
    int unsigned   cyc = 0;
    int unsigned   lat = 4;
    bit            sticky = 1'b0;
    int            cnt = 0;
    logic [W-1:0]  pend = '0;
    exp_t          exp_q[$];
    exp_t          ex_m;
    int            nst = 0;
    bit            held = 1'b0, bad = 1'b0, busy_drop = 1'b0;
    logic [W-1:0]  ha, hb;

    mont_exp_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_x        (in_x),
        .in_e        (in_e),
        .in_e_len    (in_e_len),
        .in_m        (in_m),
        .in_r        (in_r),
        .in_r2       (in_r2),
        .result      (result),
        .done        (done),
        .busy        (busy),
        .mont_start  (mont_start),
        .mont_a      (mont_a),
        .mont_b      (mont_b),
        .mont_m      (mont_m),
        .mont_result (mont_result),
        .mont_done   (mont_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // a*b*2^-W mod m by bit-serial reduction, fully reduced
    function automatic logic [W-1:0] mont_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] m);
        logic [W+1:0] t;
        t = '0;
        for (int i = 0; i < int'(W); i++) begin
            if (a[i]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, m};
            t = t >> 1;
        end
        if (t >= {2'b00, m}) t = t - {2'b00, m};
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] modmul(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] m);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return W'(p % {{W{1'b0}}, m});
    endfunction

    function automatic logic [W-1:0] modpow(input logic [W-1:0] x, input logic [EW-1:0] e,
                                           input int len, input logic [W-1:0] m);
        logic [W-1:0] r;
        r = W'(1) % m;
        for (int i = len - 1; i >= 0; i--) begin
            r = modmul(r, r, m);
            if (e[i]) r = modmul(r, x, m);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rmod(input logic [W-1:0] m);
        logic [W:0] big;
        big    = '0;
        big[W] = 1'b1;
        return W'(big % {1'b0, m});
    endfunction

    function automatic int exp_mults(input logic [EW-1:0] e, input int len);
`ifdef MONT_EXP_LADDER_EN
        return 2 + 2 * len;
`else
        int p;
        p = 0;
        for (int i = 0; i < len; i++) if (e[i]) p++;
        return 2 + len + p;
`endif
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        for (int i = 0; i < int'(W / 32); i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [W-1:0] rand_mod();
        logic [W-1:0] v;
        v = rand_w();
        v[W-1] = 1'b1;
        v[0]   = 1'b1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic timeout_fail(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired, got no event expected event", nm);
    endtask

    // Behavioural multiplier: done appears lat cycles after the start cycle
    always @(posedge clk) begin
        if (mont_start) begin
            cnt       <= int'(lat) - 1;
            pend      <= mont_mul(mont_a, mont_b, mont_m);
            mont_done <= 1'b0;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                mont_done   <= 1'b1;
                mont_result <= pend;
            end
        end else if (!sticky) begin
            mont_done <= 1'b0;
        end
    end

    // Monitor: operand hold per multiplication, and scoreboard pop on done
    always @(negedge clk) begin
        if (reset) begin
            held      = 1'b0;
            busy_drop = 1'b0;
        end else begin
            if (busy_drop) begin
                chk("busy_after_done", W'(busy), W'(0));
                busy_drop = 1'b0;
            end
            if (start && !busy) nst = 0;
            if (mont_start) begin
                nst++;
                held = 1'b1;
                bad  = 1'b0;
                ha   = mont_a;
                hb   = mont_b;
            end else if (held) begin
                if (mont_a !== ha || mont_b !== hb) bad = 1'b1;
                if (mont_done) begin
                    chk("operand_hold", W'(bad), W'(0));
                    held = 1'b0;
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1 expected no done");
                end else begin
                    ex_m = exp_q.pop_front();
                    chk("result", result, ex_m.res);
                    chk("mont_start_count", W'(nst), W'(ex_m.nstart));
                    chk("latency", W'(int'(cyc - ex_m.start_cyc) + 1), W'(ex_m.cycles));
                    chk("mont_m", mont_m, ex_m.m);
                    chk("busy_at_done", W'(busy), W'(1));
                    busy_drop = 1'b1;
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] x, input logic [EW-1:0] e, input int elen,
                         input logic [W-1:0] m);
        exp_t ex_i;
        int   eff;
        eff          = (elen > int'(EW)) ? int'(EW) : elen;
        ex_i.res     = modpow(x, e, eff, m);
        ex_i.m       = m;
        ex_i.nstart  = exp_mults(e, eff);
        ex_i.cycles  = ex_i.nstart * int'(lat) + 2 * ex_i.nstart + 3;
        in_x         = x;
        in_e         = e;
        in_e_len     = LW'(elen);
        in_m         = m;
        in_r         = rmod(m);
        in_r2        = modmul(in_r, in_r, m);
        start        = 1'b1;
        ex_i.start_cyc = cyc;
        exp_q.push_back(ex_i);
        @(posedge clk); #1;
        start    = 1'b0;
        in_x     = rand_w();
        in_e     = rand_w();
        in_m     = rand_w();
        in_r     = rand_w();
        in_r2    = rand_w();
        in_e_len = LW'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 40000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40000) begin
            timeout_fail("run_complete");
            exp_q.delete();
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_result"}, result, '0);
        chk({tag, "_done"}, W'(done), W'(0));
        chk({tag, "_busy"}, W'(busy), W'(0));
        chk({tag, "_mont_start"}, W'(mont_start), W'(0));
        chk({tag, "_mont_a"}, mont_a, '0);
        chk({tag, "_mont_b"}, mont_b, '0);
        chk({tag, "_mont_m"}, mont_m, '0);
    endtask

    initial begin
        logic [W-1:0]  m, x;
        logic [EW-1:0] e;
        int            n;

        reset    = 1'b1;
        start    = 1'b0;
        in_x     = '0;
        in_e     = '0;
        in_e_len = '0;
        in_m     = '0;
        in_r     = '0;
        in_r2    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Small operands: 2^5 mod 13, then empty and all-zero exponents
        lat = 4;
        issue(W'(2), EW'(5), 3, W'(13));
        wait_idle();
        issue(W'(2), EW'(5), 0, W'(13));
        wait_idle();
        issue(W'(2), EW'(0), 5, W'(13));
        wait_idle();

        // Full-width modulus with the common public exponent
        lat = 3;
        m = rand_mod();
        x = rand_w() % m;
        issue(x, EW'(32'h10001), 17, m);
        wait_idle();

        // Done held high between operations must not short-circuit any multiply
        sticky = 1'b1;
        issue(W'(2), EW'(5), 3, W'(13));
        wait_idle();
        issue(x, EW'(32'h10001), 17, m);
        wait_idle();
        sticky = 1'b0;
        @(posedge clk); #1;

        // Start while busy with different inputs is ignored
        lat = 2;
        issue(x, EW'(32'h2b), 6, m);
        repeat (6) @(posedge clk);
        #1;
        in_x     = W'(7);
        in_e     = EW'(3);
        in_e_len = LW'(2);
        in_m     = W'(11);
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();

        // Reset during the squaring loop aborts without done
        lat = 3;
        issue(W'(2), EW'(0), 8, W'(13));
        n = 0;
        while (nst < 3 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 1000) timeout_fail("reach_sq");
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        check_zero("abort");
        repeat (20) @(posedge clk);
        #1;
        issue(W'(3), EW'(11), 4, W'(13));
        wait_idle();

        // Dense vs sparse exponent of the same length
        issue(W'(5), EW'(8'hFF), 8, W'(13));
        wait_idle();
        issue(W'(5), EW'(8'h80), 8, W'(13));
        wait_idle();

        // Exponent length beyond the register width is clamped
        lat = 2;
        m = rand_mod();
        x = rand_w() % m;
        e = '0;
        for (int i = 0; i < 5; i++) e[$urandom_range(EW - 1, 0)] = 1'b1;
        e[EW-1] = 1'b1;
        issue(x, e, 600, m);
        wait_idle();

        // Randomized full-width runs
        for (int k = 0; k < 8; k++) begin
            lat    = $urandom_range(6, 2);
            sticky = ($urandom_range(1, 0) == 1);
            m = rand_mod();
            x = rand_w() % m;
            e = rand_w();
            issue(x, e, int'($urandom_range(40, 1)), m);
            wait_idle();
        end
        sticky = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
